// File: rtl/uart_tx_cfg_if.sv
// Purpose: handshake/data bundle between a word source and the UART transmitter.
//   start : request to send di (level-sampled by the transmitter while idle)
//   di    : word to send, DATA_BITS wide
//   out   : serial line, idles high
//   busy  : transmitter has accepted a word and the frame is in flight
//   done  : one-cycle pulse when a frame completes
// master = word source, slave = transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] di;
    logic                 out;
    logic                 busy;
    logic                 done;

    modport master (
        output start,
        output di,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  di,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Purpose: parametrised UART transmitter. One word per accepted start becomes
//   an async frame: start bit, DATA_BITS data bits LSB first, optional parity,
//   STOP_BITS stop bits. All outputs are registered.
// Ports:
//   i_clk : system clock, rising edge
//   i_rst : asynchronous reset, active-high; aborts any frame, line goes high
//   bus   : uart_tx_cfg_if slave (start/di in, out/busy/done out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for start
// S_START  | start bit (low) for one bit period
// S_DATA   | data bit r_idx on the line, LSB first
// S_PARITY | parity bit for one bit period (never entered when PARITY=0)
// S_STOP   | stop bit r_idx (high); last one returns to idle with done
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_cfg_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state, w_state;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic [IDX_W-1:0]     r_idx, w_idx;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_par, w_par;
    logic                 r_out, w_out;
    logic                 r_busy, w_busy;
    logic                 r_done, w_done;
    logic                 w_bit_end;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_out   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shift <= w_shift;
            r_par   <= w_par;
            r_out   <= w_out;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // The line value for the next bit is decided at the boundary edge so that
    // the registered output changes exactly on bit boundaries.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_shift   = r_shift;
        w_par     = r_par;
        w_out     = r_out;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_bit_end = (r_cnt == CNT_LAST);

        // Baud counter wraps at every bit boundary, so there is no drift.
        if (r_state != S_IDLE) begin
            w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_out  = 1'b1;
                w_busy = 1'b0;
                w_cnt  = '0;
                w_idx  = '0;
                if (bus.start) begin
                    w_shift = bus.di;
                    w_par   = (PARITY == 2) ? ^bus.di : ~^bus.di;
                    w_state = S_START;
                    w_out   = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_out   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_LAST) begin
                        w_idx = '0;
                        if (PARITY != 0) begin
                            w_state = S_PARITY;
                            w_out   = r_par;
                        end else begin
                            w_state = S_STOP;
                            w_out   = 1'b1;
                        end
                    end else begin
                        w_idx   = r_idx + 1'b1;
                        w_shift = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_out   = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state = S_STOP;
                    w_out   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    // r_idx is reused here to count stop bits.
                    if (r_idx == STOP_LAST) begin
                        w_state = S_IDLE;
                        w_idx   = '0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_out   = 1'b1;
                    end else begin
                        w_idx = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_out   = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign bus.out  = r_out;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg with CLKS_PER_BIT=4 on four configurations:
// 8N1, 8E1, 8O1 and 7N2. Expected frames are written out by hand as bit strings
// in line order (start, data LSB first, parity, stops), one char per bit period.
module tb_uart_tx_cfg;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_start = 1'b0;
    logic [8:0] tb_di = '0;
    int         sel = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic obs_out, obs_busy, obs_done;

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) b_8n1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) b_8e1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) b_8o1 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) b_7n2 ();

    assign b_8n1.start = tb_start && (sel == 0);
    assign b_8e1.start = tb_start && (sel == 1);
    assign b_8o1.start = tb_start && (sel == 2);
    assign b_7n2.start = tb_start && (sel == 3);
    assign b_8n1.di = tb_di[7:0];
    assign b_8e1.di = tb_di[7:0];
    assign b_8o1.di = tb_di[7:0];
    assign b_7n2.di = tb_di[6:0];

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_8n1 (.i_clk(clk), .i_rst(rst), .bus(b_8n1.slave));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_8e1 (.i_clk(clk), .i_rst(rst), .bus(b_8e1.slave));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_8o1 (.i_clk(clk), .i_rst(rst), .bus(b_8o1.slave));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
        u_7n2 (.i_clk(clk), .i_rst(rst), .bus(b_7n2.slave));

    always_comb begin
        obs_out  = b_8n1.out;
        obs_busy = b_8n1.busy;
        obs_done = b_8n1.done;
        case (sel)
            1: begin obs_out = b_8e1.out; obs_busy = b_8e1.busy; obs_done = b_8e1.done; end
            2: begin obs_out = b_8o1.out; obs_busy = b_8o1.busy; obs_done = b_8o1.done; end
            3: begin obs_out = b_7n2.out; obs_busy = b_7n2.busy; obs_done = b_7n2.done; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive a start with di; returns just after the accepting edge (edge k).
    task automatic accept(input logic [8:0] d);
        @(negedge clk);
        tb_di    = d;
        tb_start = 1'b1;
        @(posedge clk);
        #1 tb_start = 1'b0;
    endtask

    // Called right after edge k. Checks every cycle of the frame, then the done cycle.
    task automatic check_body(input string tag, input string seq);
        logic e;
        for (int c = 0; c < seq.len() * CPB; c++) begin
            @(negedge clk);
            e = (seq[c / CPB] == 8'h31);
            check({tag, " out"}, {31'd0, obs_out}, {31'd0, e});
            check({tag, " busy"}, {31'd0, obs_busy}, 32'd1);
            check({tag, " done early"}, {31'd0, obs_done}, 32'd0);
        end
        @(negedge clk);
        check({tag, " done pulse"}, {31'd0, obs_done}, 32'd1);
        check({tag, " busy end"}, {31'd0, obs_busy}, 32'd0);
        check({tag, " out end"}, {31'd0, obs_out}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst out", {31'd0, b_8n1.out}, 32'd1);
        check("rst busy", {31'd0, b_8n1.busy}, 32'd0);
        check("rst done", {31'd0, b_8n1.done}, 32'd0);
        check("rst out 7n2", {31'd0, b_7n2.out}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("idle out", {31'd0, obs_out}, 32'd1);

        // 1: 8N1 0x33
        sel = 0;
        accept(9'h033);
        check_body("t1", "0110011001");
        @(negedge clk);
        check("t1 done single", {31'd0, obs_done}, 32'd0);

        // 2: 0xE3 with even then odd parity
        sel = 1;
        accept(9'h0E3);
        check_body("t2 even", "01100011111");
        sel = 2;
        accept(9'h0E3);
        check_body("t2 odd", "01100011101");

        // 3: 7N2 0x41
        sel = 3;
        accept(9'h041);
        check_body("t3", "0100000111");

        // 4: start re-pulsed and di changed mid-frame
        sel = 0;
        accept(9'h033);
        fork
            check_body("t4", "0110011001");
            begin
                repeat (10) @(negedge clk);
                tb_di    = 9'h0CC;
                tb_start = 1'b1;
                repeat (3) @(negedge clk);
                tb_start = 1'b0;
                repeat (10) @(negedge clk);
                tb_start = 1'b1;
                @(negedge clk);
                tb_start = 1'b0;
            end
        join
        @(negedge clk);
        check("t4 no second done", {31'd0, obs_done}, 32'd0);
        check("t4 idle busy", {31'd0, obs_busy}, 32'd0);
        check("t4 idle out", {31'd0, obs_out}, 32'd1);

        // 5: start held across two frames
        @(negedge clk);
        tb_di    = 9'h033;
        tb_start = 1'b1;
        @(posedge clk);
        #1 tb_di = 9'h0E3;
        check_body("t5a", "0110011001");
        @(posedge clk);
        #1 tb_start = 1'b0;
        check_body("t5b", "0110001111");
        @(negedge clk);
        check("t5 done single", {31'd0, obs_done}, 32'd0);

        // 6: reset in the middle of data bit 3
        accept(9'h033);
        repeat (18) @(negedge clk);
        check("t6 pre out", {31'd0, obs_out}, 32'd0);
        check("t6 pre busy", {31'd0, obs_busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6 async out", {31'd0, obs_out}, 32'd1);
        check("t6 async busy", {31'd0, obs_busy}, 32'd0);
        check("t6 async done", {31'd0, obs_done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6 in rst done", {31'd0, obs_done}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6 post rst done", {31'd0, obs_done}, 32'd0);
            check("t6 post rst out", {31'd0, obs_out}, 32'd1);
        end
        accept(9'h055);
        check_body("t6", "0101010101");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
